apple_spawner: RTL
==================

// Module: apple_spawner
// PURPOSE
//  Picks the apple's grid cell and feeds apple_x/apple_y to the apple draw stage downstream.
//  Cells come from a free-running LFSR; each candidate is checked against snake occupancy.
//  A candidate found occupied is re-drawn; a bounded random search then falls back to a linear scan.
//  New positions take effect only at a blanking edge, so the apple never tears mid-frame.
// PARAMETERS
//  GRID_W     64        grid columns (<=128; apple_x is 7 bits)
//  GRID_H     48        grid rows (<=64; apple_y is 6 bits)
//  LFSR_SEED  16'hACE1  LFSR reset value (must be nonzero)
//  MAX_TRIES  16        random draws allowed before switching to linear scan
// PORTS
//  pclk         in   1   pixel clock
//  rst          in   1   reset
//  start        in   1   pulse: new game, spawn first apple
//  eaten        in   1   pulse: snake head entered apple cell
//  vblnk_in     in   1   vertical blank from timing chain
//  occ_req      out  1   occupancy query strobe
//  occ_x        out  7   queried column
//  occ_y        out  6   queried row
//  occ_hit      in   1   1 = queried cell holds snake; valid exactly 1 cycle after occ_req
//  apple_x      out  7   committed apple column
//  apple_y      out  6   committed apple row
//  apple_valid  out  1   apple present/drawable
//  busy         out  1   spawn in progress
//  board_full   out  1   no free cell found
//  apple_golden out  1   only with APPLE_GOLDEN_EN
// BEHAVIOUR
//  Reset rst, synchronous, active-high; clock pclk.
//  - Reset: all outputs 0, lfsr=LFSR_SEED, tries=0, scan counters=0, state IDLE.
//  - LFSR: 16-bit Galois, mask 16'hB400, steps every cycle in all states; if 0, reload LFSR_SEED.
//  - Candidate: cx=lfsr[6:0], cy=lfsr[13:8]; tries counter is $clog2(MAX_TRIES+1) bits.
//  - IDLE: start -> clear apple_valid, board_full, tries; busy=1; go to DRAW.
//    In IDLE, eaten with apple_valid=1 -> apple_valid=0 next cycle; busy=1; tries=0; go to DRAW.
//    eaten while apple_valid=0 or busy=1 is ignored. start+eaten same cycle: start wins.
//  - DRAW: if cx>=GRID_W or cy>=GRID_H -> tries++, stay in DRAW.
//    Otherwise occ_req=1 for one cycle, with occ_x/occ_y=cand -> WAIT.
//  - WAIT: sample occ_hit. 0 -> hold cand, go PEND. 1 -> tries++ -> DRAW.
//    In DRAW or WAIT, tries==MAX_TRIES -> SCAN.
//  - SCAN: starts at (0,0), row-major with x fastest, 2 cycles/cell (req, sample).
//    First free cell -> PEND.
//    After GRID_W*GRID_H hits: board_full=1, busy=0, apple_valid=0 -> IDLE.
//  - PEND: wait for vblnk rising edge (vblnk_in=1, registered prev=0).
//    Same cycle: apple_x/y<=cand, apple_valid=1, busy=0 -> IDLE.
//  - start in any non-IDLE state restarts at DRAW: tries=0, pending cand dropped, no commit.
//  - rst mid-operation returns everything to reset values next edge.
//  - apple_x/y stable except at commit; outputs registered; occ_x/occ_y hold last query.
// CONFIGURATION
//  APPLE_GOLDEN_EN defined: 3-bit commit counter, cleared by start.
//    apple_golden=1 on every 8th commit (counter==7 at commit); apple_golden=0 on other commits.
//  APPLE_GOLDEN_EN undefined: no counter; apple_golden port absent.
// STRUCTURE
//  snake_pkg: GRID_W/GRID_H defaults, X_W=7, Y_W=6, state encodings (IDLE,DRAW,WAIT,SCAN,PEND).
//  Sub-module apple_lfsr (seed param, step every cycle, zero-lock guard).
//  FSM plus counters stay in apple_spawner.
// TESTING
//  1. rst, start, occ_hit=0, vblnk toggling -> apple_valid=1 exactly at first vblnk rise after WAIT;
//     apple_x<64, apple_y<48, both matching a golden LFSR model from 16'hACE1.
//  2. eaten with apple_valid=1 -> apple_valid=0, busy=1 next cycle; apple_x/y unchanged until next vblnk rise.
//  3. occ_hit=1 for all cells except (5,7) -> after 16 tries SCAN; commit apple_x=5, apple_y=7.
//  4. occ_hit always 1 -> board_full=1, apple_valid=0, busy=0 after 3072 scanned cells;
//     next start clears board_full.
//  5. start asserted during WAIT, then rst asserted in PEND -> no stale commit; all outputs 0 after rst.
//  6. APPLE_GOLDEN_EN, 16 eaten cycles -> apple_golden=1 only on commits 8 and 16.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry and apple spawner state encoding
package snake_pkg;
  localparam int GRID_W = 64;
  localparam int GRID_H = 48;
  localparam int X_W = 7;
  localparam int Y_W = 6;
  typedef enum logic [2:0] {IDLE, DRAW, WAIT, SCAN, PEND} state_t;
endpackage

// File: rtl/apple_lfsr.sv
// apple_lfsr: free-running 16-bit Galois LFSR (mask B400) that reloads its seed if it ever locks at zero
module apple_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_lfsr;
  logic [15:0] w_next;
  assign w_next = r_lfsr == '0 ? SEED : {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign o_lfsr = r_lfsr;
  always_ff @(posedge pclk) r_lfsr <= rst ? SEED : w_next;
endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: picks a free grid cell for the apple and commits it at a vblank rise; APPLE_GOLDEN_EN adds apple_golden
module apple_spawner #(
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 16
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       eaten,
  input  logic       vblnk_in,
  output logic       occ_req,
  output logic [6:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_hit,
  output logic [6:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       busy,
  output logic       board_full
`ifdef APPLE_GOLDEN_EN
  ,
  output logic       apple_golden
`endif
);
  import snake_pkg::*;
  localparam int T_W = $clog2(MAX_TRIES + 1);
  state_t           r_state;
  logic [T_W-1:0]   r_tries;
  logic [X_W-1:0]   r_sx;
  logic [Y_W-1:0]   r_sy;
  logic             r_scan;
  logic             r_vprev;
  logic [15:0]      w_lfsr;
  logic [X_W-1:0]   w_cx;
  logic [Y_W-1:0]   w_cy;
  logic             w_oob;
  logic             w_last;
  logic             w_commit;
  logic             w_unused;
  apple_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .pclk   (pclk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );
  assign w_cx     = w_lfsr[6:0];
  assign w_cy     = w_lfsr[13:8];
  assign w_unused = ^{w_lfsr[15:14], w_lfsr[7]};
  assign w_oob    = int'(w_cx) >= GRID_W || int'(w_cy) >= GRID_H;
  assign w_last   = r_sx == X_W'(GRID_W - 1) && r_sy == Y_W'(GRID_H - 1);
  assign w_commit = r_state == PEND && vblnk_in && !r_vprev;
  always_ff @(posedge pclk) begin
    r_vprev <= rst ? 1'b0 : vblnk_in;
    occ_req <= 1'b0;
    if (rst) begin
      r_state     <= IDLE;
      r_tries     <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_scan      <= 1'b0;
      occ_x       <= '0;
      occ_y       <= '0;
      apple_x     <= '0;
      apple_y     <= '0;
      apple_valid <= 1'b0;
      busy        <= 1'b0;
      board_full  <= 1'b0;
    end else if (start) begin
      r_state     <= DRAW;
      r_tries     <= '0;
      apple_valid <= 1'b0;
      board_full  <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (eaten && apple_valid) begin
          apple_valid <= 1'b0;
          busy        <= 1'b1;
          r_tries     <= '0;
          r_state     <= DRAW;
        end
        DRAW: if (r_tries == T_W'(MAX_TRIES)) begin
          r_sx    <= '0;
          r_sy    <= '0;
          r_state <= SCAN;
        end else if (w_oob) begin
          r_tries <= r_tries + 1'b1;
        end else begin
          occ_req <= 1'b1;
          occ_x   <= w_cx;
          occ_y   <= w_cy;
          r_scan  <= 1'b0;
          r_state <= WAIT;
        end
        SCAN: begin
          occ_req <= 1'b1;
          occ_x   <= r_sx;
          occ_y   <= r_sy;
          r_scan  <= 1'b1;
          r_state <= WAIT;
        end
        WAIT: if (!occ_hit) begin
          r_state <= PEND;
        end else if (!r_scan) begin
          r_tries <= r_tries + 1'b1;
          r_state <= DRAW;
        end else if (w_last) begin
          board_full  <= 1'b1;
          busy        <= 1'b0;
          apple_valid <= 1'b0;
          r_state     <= IDLE;
        end else begin
          r_sx    <= r_sx == X_W'(GRID_W - 1) ? '0 : r_sx + 1'b1;
          r_sy    <= r_sx == X_W'(GRID_W - 1) ? r_sy + 1'b1 : r_sy;
          r_state <= SCAN;
        end
        PEND: if (w_commit) begin
          apple_x     <= occ_x;
          apple_y     <= occ_y;
          apple_valid <= 1'b1;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef APPLE_GOLDEN_EN
  logic [2:0] r_gcnt;
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_gcnt       <= '0;
      apple_golden <= 1'b0;
    end else if (start) begin
      r_gcnt <= '0;
    end else if (w_commit) begin
      apple_golden <= r_gcnt == 3'd7;
      r_gcnt       <= r_gcnt + 1'b1;
    end
  end
`endif
endmodule
